// File: rtl/uart_rx_core_if.sv
// Byte-level and line-level signals of the UART receiver.
// The core takes the slave side; the line driver and byte consumer take the master side.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;

    modport master (
        output RX_IN, Prescale, parity_enable, parity_type,
        input  P_DATA, Data_Valid, parity_error, stop_error, busy
    );

    modport slave (
        input  RX_IN, Prescale, parity_enable, parity_type,
        output P_DATA, Data_Valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver for 8N1/8E1/8O1 frames with 3-sample majority vote.
// Good bytes leave as a one-cycle Data_Valid pulse; errored frames raise one error pulse.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.slave  rx_if
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_next;

    logic                  rx_meta, rx_s;
    logic [PRESCALE_W-1:0] p_lat;
    logic                  pe_lat, pt_lat;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  smp0, smp1, smp2;
    logic                  par_err;

    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q, parity_error_q, stop_error_q;

    logic [PRESCALE_W-1:0] half;
    logic                  vote, vote_tick, bit_end;

    // FSM strobes
    logic start_frame, bit_clr, bit_inc, shift_en, par_chk;
    logic frame_good, frame_perr, frame_serr;

    assign half      = p_lat >> 1;
    assign vote      = (smp0 & smp1) | (smp0 & smp2) | (smp1 & smp2);
    assign vote_tick = (edge_cnt == half + PRESCALE_W'(2));
    assign bit_end   = (edge_cnt == p_lat - PRESCALE_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next  = state;
        start_frame = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        frame_good  = 1'b0;
        frame_perr  = 1'b0;
        frame_serr  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (vote_tick && vote) begin
                    state_next = IDLE;      // glitch, not a real start bit
                end else if (bit_end) begin
                    state_next = DATA;
                    bit_clr    = 1'b1;
                end
            end
            DATA: begin
                shift_en = vote_tick;
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = pe_lat ? PARITY : STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                par_chk = vote_tick;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Resolve at mid-stop so the next start edge is never missed.
                if (vote_tick) begin
                    state_next = IDLE;
                    if (!vote) begin
                        frame_serr = 1'b1;
                    end else if (par_err) begin
                        frame_perr = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the synchronizer resets to 1 (idle line) so release of
            // reset cannot fake a start edge; the shift register is reset too
            // because it is a handful of flops, not a memory array.
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            p_lat          <= '0;
            pe_lat         <= 1'b0;
            pt_lat         <= 1'b0;
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            smp0           <= 1'b0;
            smp1           <= 1'b0;
            smp2           <= 1'b0;
            par_err        <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            rx_meta        <= rx_if.RX_IN;
            rx_s           <= rx_meta;
            data_valid_q   <= frame_good;
            parity_error_q <= frame_perr;
            stop_error_q   <= frame_serr;

            if (start_frame) begin
                p_lat   <= rx_if.Prescale;
                pe_lat  <= rx_if.parity_enable;
                pt_lat  <= rx_if.parity_type;
                par_err <= 1'b0;
            end

            if (state_next == IDLE || start_frame || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state != IDLE) begin
                if (edge_cnt == half - PRESCALE_W'(1)) smp0 <= rx_s;
                if (edge_cnt == half)                  smp1 <= rx_s;
                if (edge_cnt == half + PRESCALE_W'(1)) smp2 <= rx_s;
            end

            if (shift_en) begin
                shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            end

            if (par_chk) begin
                par_err <= (vote != (pt_lat ? ~^shift_reg : ^shift_reg));
            end

            if (frame_good) begin
                p_data_q <= shift_reg;
            end
        end
    end

    assign rx_if.P_DATA       = p_data_q;
    assign rx_if.Data_Valid   = data_valid_q;
    assign rx_if.parity_error = parity_error_q;
    assign rx_if.stop_error   = stop_error_q;
    assign rx_if.busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: good frames, parity/stop errors, glitch start,
// back-to-back frames and mid-frame reset, with expected values computed here.
module tb_uart_rx_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_if ();

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (u_if.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge away from the active edge
    int        dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (u_if.Data_Valid) begin
            dv_cnt++;
            rx_q.push_back(u_if.P_DATA);
        end
        if (u_if.parity_error) pe_cnt++;
        if (u_if.stop_error)   se_cnt++;
        if (u_if.busy)         busy_cnt++;
    end

    function automatic logic par_bit(input logic [7:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    task automatic drive_bit(input logic v, input int p);
        u_if.RX_IN = v;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pbit, input logic stop_v);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(stop_v, p);
    endtask

    task automatic set_cfg(input int p, input logic pe, input logic pt);
        u_if.Prescale      = 6'(p);
        u_if.parity_enable = pe;
        u_if.parity_type   = pt;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (u_if.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (u_if.busy) check(tag, 32'(u_if.busy), 32'd0);
    endtask

    int b_dv, b_pe, b_se, b_busy, b_q;

    task automatic snap();
        b_dv   = dv_cnt;
        b_pe   = pe_cnt;
        b_se   = se_cnt;
        b_busy = busy_cnt;
        b_q    = rx_q.size();
    endtask

    initial begin
        u_if.RX_IN = 1'b1;
        set_cfg(8, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pdata", 32'(u_if.P_DATA),       32'h00);
        check("rst_dv",    32'(u_if.Data_Valid),   32'd0);
        check("rst_perr",  32'(u_if.parity_error), 32'd0);
        check("rst_serr",  32'(u_if.stop_error),   32'd0);
        check("rst_busy",  32'(u_if.busy),         32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(u_if.busy), 32'd0);

        // 1: P=8, no parity, 0xA5
        snap();
        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        check("t1_dv_cnt",  32'(dv_cnt - b_dv), 32'd1);
        check("t1_byte",    32'(rx_q.size() > b_q ? rx_q[b_q] : 8'hxx), 32'hA5);
        check("t1_pe_cnt",  32'(pe_cnt - b_pe), 32'd0);
        check("t1_se_cnt",  32'(se_cnt - b_se), 32'd0);
        check("t1_pdata",   32'(u_if.P_DATA),   32'hA5);

        // 2: P=16, even parity, 0x3C with the wrong parity bit (correct is 0)
        snap();
        set_cfg(16, 1'b1, 1'b0);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 32);
        check("t2_pe_cnt", 32'(pe_cnt - b_pe), 32'd1);
        check("t2_dv_cnt", 32'(dv_cnt - b_dv), 32'd0);
        check("t2_se_cnt", 32'(se_cnt - b_se), 32'd0);
        check("t2_pdata",  32'(u_if.P_DATA),   32'hA5);

        // 3: P=8, odd parity, 0x01 (parity 0), stop bit 0; then good 0x7E
        snap();
        set_cfg(8, 1'b1, 1'b1);
        send_frame(8'h01, 8, 1'b1, par_bit(8'h01, 1'b1), 1'b0);
        drive_bit(1'b1, 24);
        wait_idle("t3_timeout", 64);
        check("t3_se_cnt", 32'(se_cnt - b_se), 32'd1);
        check("t3_pe_cnt", 32'(pe_cnt - b_pe), 32'd0);
        check("t3_dv_cnt", 32'(dv_cnt - b_dv), 32'd0);
        check("t3_pdata",  32'(u_if.P_DATA),   32'hA5);
        snap();
        send_frame(8'h7E, 8, 1'b1, par_bit(8'h7E, 1'b1), 1'b1);
        drive_bit(1'b1, 16);
        check("t3b_dv_cnt", 32'(dv_cnt - b_dv), 32'd1);
        check("t3b_byte",   32'(rx_q.size() > b_q ? rx_q[b_q] : 8'hxx), 32'h7E);
        check("t3b_err",    32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);

        // 4: P=16, 3-cycle low glitch
        snap();
        set_cfg(16, 1'b0, 1'b0);
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 6);
        check("t4_busy_seen", 32'(busy_cnt > b_busy), 32'd1);
        wait_idle("t4_timeout", 64);
        drive_bit(1'b1, 8);
        check("t4_busy",   32'(u_if.busy), 32'd0);
        check("t4_pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
        check("t4_pdata",  32'(u_if.P_DATA), 32'h7E);

        // 5: P=32, back-to-back 0x00, 0xFF, 0x55
        snap();
        set_cfg(32, 1'b0, 1'b0);
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 64);
        check("t5_dv_cnt", 32'(dv_cnt - b_dv), 32'd3);
        check("t5_byte0",  32'(rx_q.size() > b_q     ? rx_q[b_q]     : 8'hxx), 32'h00);
        check("t5_byte1",  32'(rx_q.size() > b_q + 1 ? rx_q[b_q + 1] : 8'hxx), 32'hFF);
        check("t5_byte2",  32'(rx_q.size() > b_q + 2 ? rx_q[b_q + 2] : 8'hxx), 32'h55);
        check("t5_err",    32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);

        // 6: P=8, reset in the middle of bit 4 of 0xC3, then 0x81
        set_cfg(8, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), 8);
        drive_bit(1'b0, 4);
        check("t6_busy_before", 32'(u_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy",  32'(u_if.busy),   32'd0);
        check("t6_rst_pdata", 32'(u_if.P_DATA), 32'h00);
        check("t6_rst_dv",    32'(u_if.Data_Valid), 32'd0);
        u_if.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 24);
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        check("t6_dv_cnt", 32'(dv_cnt - b_dv), 32'd1);
        check("t6_byte",   32'(rx_q.size() > b_q ? rx_q[b_q] : 8'hxx), 32'h81);
        check("t6_pdata",  32'(u_if.P_DATA), 32'h81);
        check("t6_err",    32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
